cfs_edge_gen: RTL and testbench

Transmit-side counterpart of the team's edge detector. It converts single-cycle event requests into clean, registered level pulses of programmable width and polarity on one output line. It guarantees a minimum inactive gap between pulses, so a downstream edge detector sees exactly one edge per request. Requests that arrive while a pulse is in flight are queued in a saturating pending counter, and loss on overflow is flagged.

---
 rtl/cfs_pkg.sv | 17 +
 rtl/cfs_edge_gen_if.sv | 31 +++
 rtl/cfs_sat_counter.sv | 28 ++
 rtl/cfs_edge_gen.sv | 114 +++++++++++
 tb/tb_cfs_edge_gen.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cfs_pkg.sv
// rtl/cfs_pkg.sv - shared types and helpers for the edge pulse generator
package cfs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } cfs_edge_gen_state_t;

  // Phase counter must hold values up to max(high, low) - 1; one extra bit of headroom keeps it uniform.
  function automatic int phase_w(input int high_cycles, input int low_cycles);
    int m;
    m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return (m + 1 <= 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cfs_edge_gen_if.sv
// rtl/cfs_edge_gen_if.sv - request/status bundle for the edge pulse generator
interface cfs_edge_gen_if #(
  parameter int PEND_W = 4
);

  logic              req;
  logic              clr_ovf;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              ovf;

  modport master (
    output req,
    output clr_ovf,
    input  out,
    input  busy,
    input  pending,
    input  ovf
  );

  modport slave (
    input  req,
    input  clr_ovf,
    output out,
    output busy,
    output pending,
    output ovf
  );

endinterface

// File: rtl/cfs_sat_counter.sv
// rtl/cfs_sat_counter.sv - up/down counter that saturates at all-ones and reports dropped increments
module cfs_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_drop
);

  localparam logic [W-1:0] MAX = '1;

  // A simultaneous inc/dec is a net no-op, so it never drops even when full.
  assign sat_drop = inc && !dec && (count == MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !dec && (count != MAX)) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/cfs_edge_gen.sv
// rtl/cfs_edge_gen.sv - turns single-cycle requests into fixed-width pulses with a guaranteed idle gap
module cfs_edge_gen
  import cfs_pkg::*;
#(
  parameter bit EDGE        = 1'b1,
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 1,
  parameter int PEND_W      = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  cfs_edge_gen_if.slave  bus
);

  localparam int PH_W = phase_w(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_CYCLES - 1);
  localparam logic [PH_W-1:0] LOW_LOAD  = PH_W'(LOW_CYCLES - 1);

  generate
    if (HIGH_CYCLES < 1 || LOW_CYCLES < 1) begin : g_bad_params
      $error("cfs_edge_gen: HIGH_CYCLES and LOW_CYCLES must both be >= 1");
    end
  endgenerate

  cfs_edge_gen_state_t state;
  logic [PH_W-1:0]     phase;
  logic                out_q;
  logic                busy_q;
  logic                ovf_q;

  logic last_gap;
  logic have_pend;
  logic direct;
  logic pend_inc;
  logic pend_dec;
  logic drop;

  assign last_gap  = (state == GAP) && (phase == '0);
  assign have_pend = (bus.pending != '0);
  // A request is used on the spot only when no older event is waiting to start.
  assign direct    = bus.req && ((state == IDLE) || (last_gap && !have_pend));
  assign pend_dec  = last_gap && have_pend;
  assign pend_inc  = bus.req && !direct;

  cfs_sat_counter #(
    .W(PEND_W)
  ) u_pending (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (pend_inc),
    .dec      (pend_dec),
    .count    (bus.pending),
    .sat_drop (drop)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      phase  <= '0;
      out_q  <= !EDGE;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        ovf_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.req) begin
            state  <= ACTIVE;
            phase  <= HIGH_LOAD;
            out_q  <= EDGE;
            busy_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (phase == '0) begin
            state <= GAP;
            phase <= LOW_LOAD;
            out_q <= !EDGE;
          end else begin
            phase <= phase - PH_W'(1);
          end
        end
        GAP: begin
          if (phase != '0) begin
            phase <= phase - PH_W'(1);
          end else if (have_pend || bus.req) begin
            state <= ACTIVE;
            phase <= HIGH_LOAD;
            out_q <= EDGE;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          phase  <= '0;
          out_q  <= !EDGE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cfs_edge_gen.sv
// tb/tb_cfs_edge_gen.sv - self-checking bench for cfs_edge_gen against a window-based reference model
module tb_cfs_edge_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  cfs_edge_gen_if #(.PEND_W(4)) ifa ();
  cfs_edge_gen_if #(.PEND_W(2)) ifb ();

  cfs_edge_gen #(
    .EDGE(1'b1), .HIGH_CYCLES(2), .LOW_CYCLES(1), .PEND_W(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );

  cfs_edge_gen #(
    .EDGE(1'b0), .HIGH_CYCLES(3), .LOW_CYCLES(2), .PEND_W(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each pulse occupies a window of HIGH+LOW cycles; m_rem counts window cycles left.
  int P_H[2]    = '{2, 3};
  int P_L[2]    = '{1, 2};
  int P_MAX[2]  = '{15, 3};
  bit P_EDGE[2] = '{1'b1, 1'b0};
  int m_rem[2], m_pend[2], m_ovf[2], m_starts[2], obs_edges[2];
  logic prev_out[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rem[d]    = 0;
      m_pend[d]   = 0;
      m_ovf[d]    = 0;
      prev_out[d] = !P_EDGE[d];
    end
  endtask

  task automatic model_step(input int d, input bit r, input bit c);
    bit drop;
    drop = 1'b0;
    if (m_rem[d] <= 1) begin
      if (m_pend[d] + int'(r) > 0) begin
        m_rem[d]  = P_H[d] + P_L[d];
        m_pend[d] = m_pend[d] + int'(r) - 1;
        m_starts[d]++;
      end else begin
        m_rem[d] = 0;
      end
    end else begin
      m_rem[d]--;
      if (r) begin
        if (m_pend[d] == P_MAX[d]) drop = 1'b1;
        else m_pend[d]++;
      end
    end
    if (drop) m_ovf[d] = 1;
    else if (c) m_ovf[d] = 0;
  endtask

  task automatic compare_models(input string tag);
    logic o[2], b[2], v[2];
    logic [3:0] p[2];
    logic exp_out;
    o[0] = ifa.out; b[0] = ifa.busy; v[0] = ifa.ovf; p[0] = ifa.pending;
    o[1] = ifb.out; b[1] = ifb.busy; v[1] = ifb.ovf; p[1] = {2'b00, ifb.pending};
    for (int d = 0; d < 2; d++) begin
      exp_out = (m_rem[d] > P_L[d]) ? P_EDGE[d] : !P_EDGE[d];
      check($sformatf("%s.out%0d", tag, d), 32'(o[d]), 32'(exp_out));
      check($sformatf("%s.busy%0d", tag, d), 32'(b[d]), 32'(m_rem[d] > 0));
      check($sformatf("%s.pend%0d", tag, d), 32'(p[d]), 32'(m_pend[d]));
      check($sformatf("%s.ovf%0d", tag, d), 32'(v[d]), 32'(m_ovf[d]));
      if (o[d] === P_EDGE[d] && prev_out[d] !== P_EDGE[d]) obs_edges[d]++;
      prev_out[d] = o[d];
    end
  endtask

  task automatic step(input bit ra, input bit ca, input bit rb, input bit cb);
    ifa.req = ra; ifa.clr_ovf = ca;
    ifb.req = rb; ifb.clr_ovf = cb;
    @(posedge clk);
    model_step(0, ra, ca);
    model_step(1, rb, cb);
    #1;
    compare_models("cyc");
  endtask

  task automatic do_reset();
    ifa.req = 1'b0; ifa.clr_ovf = 1'b0;
    ifb.req = 1'b0; ifb.clr_ovf = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    compare_models("reset");
  endtask

  int edges_before;
  bit exp_single_a[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  bit exp_single_b[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int exp_b2b_pend[8] = '{0, 1, 2, 1, 1, 1, 0, 0};
  bit exp_b2b_out[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    m_starts  = '{0, 0};
    obs_edges = '{0, 0};
    do_reset();
    check("reset_out_a", 32'(ifa.out), 32'd0);
    check("reset_out_b", 32'(ifb.out), 32'd1);

    // Single event on A and on inverted-polarity B.
    for (int i = 0; i < 5; i++) begin
      step(i == 0, 1'b0, i == 0, 1'b0);
      check($sformatf("single_out_a[%0d]", i + 1), 32'(ifa.out), 32'(exp_single_a[i]));
      check($sformatf("single_out_b[%0d]", i + 1), 32'(ifb.out), 32'(exp_single_b[i]));
    end
    check("single_busy_a", 32'(ifa.busy), 32'd0);

    // Back-to-back requests on A.
    edges_before = obs_edges[0];
    for (int i = 0; i < 8; i++) begin
      step(i < 3, 1'b0, 1'b0, 1'b0);
      check($sformatf("b2b_pend[%0d]", i + 1), 32'(ifa.pending), 32'(exp_b2b_pend[i]));
      check($sformatf("b2b_out[%0d]", i + 1), 32'(ifa.out), 32'(exp_b2b_out[i]));
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_edges", 32'(obs_edges[0] - edges_before), 32'd3);

    // Enqueue and consume in the same cycle on A.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("coll_pre_pend", 32'(ifa.pending), 32'd1);
    check("coll_pre_out", 32'(ifa.out), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("coll_pend", 32'(ifa.pending), 32'd1);
    check("coll_out", 32'(ifa.out), 32'd1);
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Overflow on B with a 2-bit pending counter.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ovf_pend", 32'(ifb.pending), 32'd3);
    check("ovf_set", 32'(ifb.ovf), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(ifb.ovf), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("ovf_set_wins", 32'(ifb.ovf), 32'd1);
    repeat (30) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_drained", 32'(ifb.busy), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 10);
    end
    repeat (40) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("pulses_a", 32'(obs_edges[0]), 32'(m_starts[0]));
    check("pulses_b", 32'(obs_edges[1]), 32'(m_starts[1]));

    // Reset while A is mid-pulse with two events queued.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_pend", 32'(ifa.pending), 32'd2);
    check("mid_out", 32'(ifa.out), 32'd1);
    #2;
    reset_n = 1'b0;
    ifa.req = 1'b0;
    model_reset();
    #1;
    check("rst_out", 32'(ifa.out), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_pend", 32'(ifa.pending), 32'd0);
    check("rst_ovf", 32'(ifa.ovf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    edges_before = obs_edges[0];
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_no_resume", 32'(obs_edges[0] - edges_before), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
